// File: rtl/decode_operand_stage.sv
// decode_operand_stage
//   Decode/operand-fetch pipeline stage. Each used source operand is resolved
//   from RIP synthesis (pc + length), from the youngest matching forwarding
//   slot, or from the register file view. A matching slot whose value is not
//   yet produced raises a load-use hazard and blocks the queue head.
//   The resolved instruction is registered behind a valid/ready handshake
//   with a two-state (EMPTY/FULL) output register.
//
//   Optional build macro: DECODE_OPND_PERF_EN
//     When defined, adds output perf_hazard_cycles[31:0]. This is a
//     saturating count of cycles with hazard=1 && !flush, cleared only by rst.
module decode_operand_stage #(
  parameter int XLEN      = 64,
  parameter int REG_N     = 17,
  parameter int REG_W     = $clog2(REG_N),
  parameter int RIP_IDX   = 16,
  parameter int SRC_N     = 3,
  parameter int FWD_N     = 3,
  parameter int PAYLOAD_W = 64,
  parameter int PC_W      = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_W-1:0]        in_pc,
  input  logic [3:0]             in_len,
  input  logic [SRC_N*REG_W-1:0] in_src,
  input  logic [SRC_N-1:0]       in_use,
  input  logic [PAYLOAD_W-1:0]   in_payload,
  input  logic [REG_N*XLEN-1:0]  gpr,
  input  logic [FWD_N-1:0]       fwd_valid,
  input  logic [FWD_N-1:0]       fwd_rdy,
  input  logic [FWD_N*REG_W-1:0] fwd_dst,
  input  logic [FWD_N*XLEN-1:0]  fwd_val,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [PAYLOAD_W-1:0]   out_payload,
  output logic [SRC_N*XLEN-1:0]  out_opnd,
  output logic                   hazard
`ifdef DECODE_OPND_PERF_EN
  ,
  output logic [31:0]            perf_hazard_cycles
`endif
);

  // Width wide enough to add pc and length before truncating to XLEN.
  localparam int SUM_W = (PC_W > XLEN) ? PC_W : XLEN;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d;
  logic [SRC_N*XLEN-1:0]  opnd_q, opnd_d;

  logic [SUM_W-1:0]       rip_sum_s;
  logic [XLEN-1:0]        rip_s;
  logic [SRC_N*XLEN-1:0]  opnd_s;
  logic [SRC_N-1:0]       src_haz_s;
  logic                   found_s;
  logic [REG_W-1:0]       idx_s;
  logic                   hazard_s;
  logic                   in_ready_s;
  logic                   accept_s;

  // RIP value: pc plus zero-extended length, wrapping at XLEN bits.
  always_comb begin
    rip_sum_s = SUM_W'(in_pc) + SUM_W'(in_len);
    rip_s     = rip_sum_s[XLEN-1:0];
  end

  // Per-source operand resolution: RIP, youngest forwarding slot, or gpr.
  // The first matching slot decides alone; an unready match is a hazard
  // even when an older slot holds a ready value for the same register.
  always_comb begin
    opnd_s    = '0;
    src_haz_s = '0;
    found_s   = 1'b0;
    idx_s     = '0;
    for (int j = 0; j < SRC_N; j++) begin
      idx_s   = in_src[j*REG_W +: REG_W];
      found_s = 1'b0;
      if (!in_use[j]) begin
        opnd_s[j*XLEN +: XLEN] = '0;
      end else if (idx_s == REG_W'(RIP_IDX)) begin
        opnd_s[j*XLEN +: XLEN] = rip_s;
      end else if (int'(idx_s) >= REG_N) begin
        // Out-of-range register index reads as zero and never stalls.
        opnd_s[j*XLEN +: XLEN] = '0;
      end else begin
        for (int k = 0; k < FWD_N; k++) begin
          if (!found_s && fwd_valid[k] &&
              (fwd_dst[k*REG_W +: REG_W] == idx_s)) begin
            found_s = 1'b1;
            if (fwd_rdy[k]) begin
              opnd_s[j*XLEN +: XLEN] = fwd_val[k*XLEN +: XLEN];
            end else begin
              src_haz_s[j] = 1'b1;
            end
          end else begin
            found_s = found_s;
          end
        end
        if (!found_s) begin
          opnd_s[j*XLEN +: XLEN] = gpr[int'(idx_s)*XLEN +: XLEN];
        end else begin
          opnd_s[j*XLEN +: XLEN] = opnd_s[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Handshake: a hazard only matters for a valid head; flush blocks intake.
  always_comb begin
    hazard_s   = in_valid && (|src_haz_s);
    in_ready_s = !flush && !hazard_s && ((state_q == ST_EMPTY) || out_ready);
    accept_s   = in_valid && in_ready_s;
  end

  // Output register state and payload: asynchronous clear, load on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      pc_q      <= '0;
      payload_q <= '0;
      opnd_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      payload_q <= payload_d;
      opnd_q    <= opnd_d;
    end
  end

  // Next state: flush empties unconditionally, accept fills, drain empties.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    payload_d = payload_q;
    opnd_d    = opnd_q;
    if (accept_s) begin
      pc_d      = in_pc;
      payload_d = in_payload;
      opnd_d    = opnd_s;
    end else begin
      pc_d      = pc_q;
      payload_d = payload_q;
      opnd_d    = opnd_q;
    end
    case (state_q)
      ST_EMPTY: begin
        if (flush) begin
          state_d = ST_EMPTY;
        end else if (accept_s) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (flush) begin
          state_d = ST_EMPTY;
        end else if (accept_s) begin
          state_d = ST_FULL;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Outputs: registered copies plus the combinational handshake signals.
  always_comb begin
    out_valid   = (state_q == ST_FULL);
    out_pc      = pc_q;
    out_payload = payload_q;
    out_opnd    = opnd_q;
    hazard      = hazard_s;
    in_ready    = in_ready_s;
  end

`ifdef DECODE_OPND_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Hazard-cycle counter next value: count unflushed hazards, saturate.
  always_comb begin
    if (hazard_s && !flush && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // Hazard-cycle counter register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  // Counter output.
  always_comb begin
    perf_hazard_cycles = perf_q;
  end
`endif

endmodule

// File: doc/decode_operand_stage.md
# decode_operand_stage

Parametrised decode/operand-fetch pipeline stage. It resolves up to SRC_N source operands per instruction from the register file, or from FWD_N forwarding slots ordered youngest first. It detects load-use hazards when a matching slot's value is not yet produced, synthesises RIP as pc+length, and registers the result behind a valid/ready handshake. It sits between the micro-instruction queue head and the execute stage, and replaces the fixed three-operand, always-advance decode register.

## Interface
Parameters:
- XLEN, 64, operand/register width
- REG_N, 17, architectural registers including RIP
- REG_W, $clog2(REG_N), register index width
- RIP_IDX, 16, index decoded as RIP
- SRC_N, 3, source operand ports
- FWD_N, 3, forwarding slots; slot 0 is youngest
- PAYLOAD_W, 64, opaque micro-instruction bits passed through
- PC_W, 64, pc width

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard held and incoming instruction
- in_valid  in  1  queue head valid
- in_ready  out  1  stage accepts head this cycle
- in_pc  in  PC_W  instruction pc
- in_len  in  4  instruction length in bytes (1..15)
- in_src  in  SRC_N*REG_W  source indices, port j at [j*REG_W +: REG_W]
- in_use  in  SRC_N  source j is read
- in_payload  in  PAYLOAD_W  passthrough
- gpr  in  REG_N*XLEN  register file read view
- fwd_valid  in  FWD_N  slot k carries a pending write
- fwd_rdy  in  FWD_N  slot k value is available (0 = load in flight)
- fwd_dst  in  FWD_N*REG_W  slot k destination index
- fwd_val  in  FWD_N*XLEN  slot k value
- out_valid  out  1  registered instruction valid
- out_ready  in  1  execute accepts
- out_pc, out_payload  out  PC_W, PAYLOAD_W  registered copies
- out_opnd  out  SRC_N*XLEN  resolved operands
- hazard  out  1  combinational: head blocked by an unready forward

## Operation
- Per source j (in_use[j]=1): if in_src[j]==RIP_IDX → value = in_pc + zero-extended in_len, truncated to XLEN, never hazardous. Otherwise, the lowest k with fwd_valid[k] && fwd_dst[k]==in_src[j] wins. If fwd_rdy[k]=1 → fwd_val[k]. If fwd_rdy[k]=0 → hazard, and older slots are NOT consulted. No match → gpr[in_src[j]].
- in_use[j]=0 → operand j is 0 and contributes no hazard.
- in_src index ≥ REG_N (not RIP_IDX) → operand 0, no hazard.
- hazard = in_valid && OR of per-source hazards.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Output register has two states. EMPTY (out_valid=0) and FULL (out_valid=1).
- Load when in_valid && in_ready: FULL next cycle with new data.
- FULL && out_ready && no load: EMPTY next cycle.
- FULL && !out_ready: hold all outputs stable.
- flush: EMPTY next cycle regardless of other inputs; the head is not consumed.

## Timing
- Latency 1: operands sampled from gpr/fwd in the accept cycle appear on the next edge.
- Full throughput: back-to-back accepts while out_ready=1.
- Reset (async on rst rise): out_valid=0, out_pc=0, out_payload=0, out_opnd=0, perf counter 0. in_ready follows its formula; it is 0 during flush or hazard.
- Reset mid-transfer drops the held instruction. No output is produced until a new accept after rst falls.
- flush and hazard on the same cycle: flush wins, out_valid=0 next.
- Hazard while FULL && out_ready: instruction drains and the stage goes EMPTY (bubble).

## Configuration
- DECODE_OPND_PERF_EN defined: adds output perf_hazard_cycles [31:0]. It increments on each cycle with hazard=1 && !flush, saturates at 32'hFFFF_FFFF, and is cleared by rst only.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Register forwarding priority: gpr[3]=5, slot1 {dst 3, val 7, rdy 1}, slot0 {dst 3, val 9, rdy 1}, in_src0=3, accept → next cycle out_opnd[0]=9.
- Load-use hazard: slot0 {dst 3, rdy 0}, slot2 {dst 3, val 4, rdy 1}, in_valid=1 → hazard=1, in_ready=0, no accept. After fwd_rdy[0]=1, val 0xAB → accept, out_opnd=0xAB.
- RIP synthesis: in_src1=16, in_pc=0x1000, in_len=5 → out_opnd[1]=0x1005. With in_pc=all ones and in_len=1 → out_opnd[1] wraps to 0.
- Backpressure: FULL, out_ready=0 for 4 cycles with a new head waiting → outputs unchanged, in_ready=0. out_ready=1 → new head is accepted in that same cycle.
- Flush and reset: FULL, flush=1 with in_valid=1 → out_valid=0 next, head not consumed. Assert rst mid-stream → outputs immediately 0.
- With DECODE_OPND_PERF_EN: hold hazard 10 cycles, one of them with flush → perf_hazard_cycles=9.
